// File: rtl/seq_ctrl_nch.sv
// N-channel round-robin phase sequencer: grants one channel at a time and walks it
// through timed GREEN -> YELLOW -> ALLRED phases with registered one-hot lamp outputs.
module seq_ctrl_nch #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 6,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   grn,
    output logic [NCH-1:0]   yel,
    output logic [NCH-1:0]   red,
    output logic [1:0]       phase,
    output logic [CW-1:0]    cur,
    output logic [CNT_W-1:0] tmr,
    output logic [NCH-1:0]   pend
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } phase_t;

    phase_t           phase_reg, phase_next;
    logic [CW-1:0]    cur_reg, cur_next;
    logic [CNT_W-1:0] tmr_reg, tmr_next;
    logic [NCH-1:0]   pend_reg, pend_next;
    logic [NCH-1:0]   grn_reg, grn_next;
    logic [NCH-1:0]   yel_reg, yel_next;
    logic [NCH-1:0]   red_reg, red_next;

    logic [NCH-1:0]   v;
    logic [NCH-1:0]   cur_oh, pick_oh, nxt_oh, clr;
    logic [CW-1:0]    pick;
    logic [CW-1:0]    idx;
    logic             others;
    logic             enter_green;

    assign v      = pend_reg | req;
    assign others = |(v & ~cur_oh);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_onehot
            assign cur_oh[gi]  = (cur_reg  == CW'(gi));
            assign pick_oh[gi] = (pick     == CW'(gi));
            assign nxt_oh[gi]  = (cur_next == CW'(gi));
        end
    endgenerate

    // Walk downward so the nearest candidate after cur wins; cur itself (i == NCH) is last.
    always_comb begin
        pick = cur_reg;
        idx  = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = CW'((int'(cur_reg) + i) % NCH);
            if (v[idx]) pick = idx;
        end
    end

    always_comb begin
        phase_next  = phase_reg;
        cur_next    = cur_reg;
        tmr_next    = tmr_reg;
        enter_green = 1'b0;
        case (phase_reg)
            IDLE: begin
                if (en && (|v)) begin
                    phase_next  = GREEN;
                    cur_next    = pick;
                    tmr_next    = CNT_W'(GREEN_T - 1);
                    enter_green = 1'b1;
                end
            end
            GREEN: begin
                if (tmr_reg != '0) begin
                    tmr_next = tmr_reg - CNT_W'(1);
                end else if (others || !en) begin
                    phase_next = YELLOW;
                    tmr_next   = CNT_W'(YELLOW_T - 1);
                end
            end
            YELLOW: begin
                if (tmr_reg != '0) begin
                    tmr_next = tmr_reg - CNT_W'(1);
                end else begin
                    phase_next = ALLRED;
                    tmr_next   = CNT_W'(ALLRED_T - 1);
                end
            end
            ALLRED: begin
                if (tmr_reg != '0) begin
                    tmr_next = tmr_reg - CNT_W'(1);
                end else if (en && (|v)) begin
                    phase_next  = GREEN;
                    cur_next    = pick;
                    tmr_next    = CNT_W'(GREEN_T - 1);
                    enter_green = 1'b1;
                end else begin
                    phase_next = IDLE;
                    tmr_next   = '0;
                end
            end
        endcase

        // The served channel's own request is absorbed while it holds green.
        clr       = (enter_green ? pick_oh : '0) | ((phase_reg == GREEN) ? cur_oh : '0);
        pend_next = (pend_reg | req) & ~clr;
        grn_next  = (phase_next == GREEN)  ? nxt_oh : '0;
        yel_next  = (phase_next == YELLOW) ? nxt_oh : '0;
        red_next  = ~(grn_next | yel_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= IDLE;
            cur_reg   <= '0;
            tmr_reg   <= '0;
            pend_reg  <= '0;
            grn_reg   <= '0;
            yel_reg   <= '0;
            red_reg   <= '1;
        end else begin
            phase_reg <= phase_next;
            cur_reg   <= cur_next;
            tmr_reg   <= tmr_next;
            pend_reg  <= pend_next;
            grn_reg   <= grn_next;
            yel_reg   <= yel_next;
            red_reg   <= red_next;
        end
    end

    assign phase = phase_reg;
    assign cur   = cur_reg;
    assign tmr   = tmr_reg;
    assign pend  = pend_reg;
    assign grn   = grn_reg;
    assign yel   = yel_reg;
    assign red   = red_reg;

endmodule

// File: tb/tb_seq_ctrl_nch.sv
// Directed bench for seq_ctrl_nch with NCH=4, GREEN_T=4, YELLOW_T=2, ALLRED_T=1.
// Snapshot layout: {phase, cur, tmr, grn, yel, red, pend}.
module tb_seq_ctrl_nch;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] grn, yel, red, pend;
    logic [1:0] phase;
    logic [1:0] cur;
    logic [5:0] tmr;

    int checks   = 0;
    int failures = 0;

    logic [25:0] snap;
    assign snap = {phase, cur, tmr, grn, yel, red, pend};

    seq_ctrl_nch #(
        .NCH(4), .CNT_W(6), .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grn(grn), .yel(yel), .red(red),
        .phase(phase), .cur(cur), .tmr(tmr), .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected snapshot; lamps follow from phase and granted channel.
    function automatic logic [25:0] exp_snap(input logic [1:0] ph, input logic [1:0] cu,
                                             input logic [5:0] tm, input logic [3:0] pe);
        logic [3:0] oh, g, y;
        oh = 4'b0001 << cu;
        g  = (ph == 2'd1) ? oh : 4'b0000;
        y  = (ph == 2'd2) ? oh : 4'b0000;
        return {ph, cu, tm, g, y, ~(g | y), pe};
    endfunction

    function automatic logic [13:0] st(input int ph, input int cu, input int tm, input logic [3:0] pe);
        return {ph[1:0], cu[1:0], tm[5:0], pe};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [25:0] e;
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;
        #1;
        e = exp_snap(0, 0, 0, 4'b0000);
        checks++;
        if (snap !== e) begin
            failures++;
            $display("FAIL reset_state: got %b want %b", snap, e);
        end
        do_reset();
    endtask

    task automatic test_single_grant();
        int tseq [5] = '{2, 1, 0, 0, 0};
        logic [25:0] e;
        en  = 1'b1;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        e = exp_snap(1, 2, 3, 4'b0000);
        checks++;
        if (snap !== e) begin
            failures++;
            $display("FAIL grant_latency: got %b want %b", snap, e);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            e = exp_snap(1, 2, tseq[i][5:0], 4'b0000);
            checks++;
            if (snap !== e) begin
                failures++;
                $display("FAIL green_count step %0d: got %b want %b", i, snap, e);
            end
        end
    endtask

    task automatic test_preempt();
        logic [13:0] tbl [4];
        logic [25:0] e;
        tbl = '{st(2, 2, 1, 4'b0001), st(2, 2, 0, 4'b0001), st(3, 2, 0, 4'b0001), st(1, 0, 3, 4'b0000)};
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            req = 4'b0000;
            e = exp_snap(tbl[i][13:12], tbl[i][11:10], tbl[i][9:4], tbl[i][3:0]);
            checks++;
            if (snap !== e) begin
                failures++;
                $display("FAIL preempt step %0d: got %b want %b", i, snap, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [13:0] tbl [25];
        logic [25:0] e;
        tbl = '{st(1, 2, 2, 4'b1011), st(1, 2, 1, 4'b1011), st(1, 2, 0, 4'b1011),
                st(2, 2, 1, 4'b1011), st(2, 2, 0, 4'b1011), st(3, 2, 0, 4'b1011),
                st(1, 3, 3, 4'b0011), st(1, 3, 2, 4'b0011), st(1, 3, 1, 4'b0011), st(1, 3, 0, 4'b0011),
                st(2, 3, 1, 4'b0011), st(2, 3, 0, 4'b0011), st(3, 3, 0, 4'b0011),
                st(1, 0, 3, 4'b0010), st(1, 0, 2, 4'b0010), st(1, 0, 1, 4'b0010), st(1, 0, 0, 4'b0010),
                st(2, 0, 1, 4'b0010), st(2, 0, 0, 4'b0010), st(3, 0, 0, 4'b0010),
                st(1, 1, 3, 4'b0000), st(1, 1, 2, 4'b0000), st(1, 1, 1, 4'b0000), st(1, 1, 0, 4'b0000),
                st(1, 1, 0, 4'b0000)};
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        tick();
        req = 4'b1011;
        for (int i = 0; i < 25; i++) begin
            tick();
            req = 4'b0000;
            e = exp_snap(tbl[i][13:12], tbl[i][11:10], tbl[i][9:4], tbl[i][3:0]);
            checks++;
            if (snap !== e) begin
                failures++;
                $display("FAIL round_robin step %0d: got %b want %b", i, snap, e);
            end
        end
    endtask

    task automatic test_en_drop();
        logic [13:0] tbl [8];
        logic [25:0] e;
        tbl = '{st(1, 0, 2, 4'b1000), st(1, 0, 1, 4'b1000), st(1, 0, 0, 4'b1000),
                st(2, 0, 1, 4'b1000), st(2, 0, 0, 4'b1000), st(3, 0, 0, 4'b1000),
                st(0, 0, 0, 4'b1000), st(0, 0, 0, 4'b1000)};
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        tick();
        req = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            tick();
            req = 4'b0000;
            en  = 1'b0;
            e = exp_snap(tbl[i][13:12], tbl[i][11:10], tbl[i][9:4], tbl[i][3:0]);
            checks++;
            if (snap !== e) begin
                failures++;
                $display("FAIL en_drop step %0d: got %b want %b", i, snap, e);
            end
        end
        // Retained pending request is served once the controller is re-enabled.
        en = 1'b1;
        tick();
        e = exp_snap(1, 3, 3, 4'b0000);
        checks++;
        if (snap !== e) begin
            failures++;
            $display("FAIL en_resume: got %b want %b", snap, e);
        end
    endtask

    task automatic test_async_reset();
        logic [25:0] e;
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        tick();
        e = exp_snap(2, 0, 1, 4'b0010);
        checks++;
        if (snap !== e) begin
            failures++;
            $display("FAIL pre_reset_yellow: got %b want %b", snap, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        e = exp_snap(0, 0, 0, 4'b0000);
        checks++;
        if (snap !== e) begin
            failures++;
            $display("FAIL async_reset: got %b want %b", snap, e);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (snap !== e) begin
                failures++;
                $display("FAIL idle_after_reset step %0d: got %b want %b", i, snap, e);
            end
        end
    endtask

    task automatic test_rest_single();
        logic [25:0] e;
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = exp_snap(1, 1, (i < 4) ? 6'(3 - i) : 6'd0, 4'b0000);
            checks++;
            if (snap !== e) begin
                failures++;
                $display("FAIL rest_single step %0d: got %b want %b", i, snap, e);
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        #3;
        test_reset();
        test_single_grant();
        test_preempt();
        test_round_robin();
        test_en_drop();
        test_async_reset();
        test_rest_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_ctrl_nch.md
Name: seq_ctrl_nch

Overview:
- Parametrised N-channel sequencing controller; successor to the fixed s298-class control cones.
- Arbitrates sticky per-channel requests in round-robin order.
- Steps the granted channel through timed GREEN -> YELLOW -> ALLRED phases and drives registered one-hot phase outputs.
- Sits as a standalone control block in the benchmark-style sequential suite, mapped to the same standard-cell library.

Parameters:
NCH, 4, number of channels (2..16)
CNT_W, 6, phase timer width
GREEN_T, 20, GREEN phase length in cycles (1..2^CNT_W)
YELLOW_T, 3, YELLOW phase length in cycles (1..2^CNT_W)
ALLRED_T, 2, ALLRED phase length in cycles (1..2^CNT_W)

Ports:
CK  input  1  clock, rising edge
RN  input  1  asynchronous active-low reset
EN  input  1  controller enable; when low, finishes the current cycle and returns to IDLE
REQ  input  NCH  per-channel service request; level or single-cycle pulse
GRN  output  NCH  one-hot green, registered
YEL  output  NCH  one-hot yellow, registered
RED  output  NCH  equals ~(GRN|YEL), registered
PHASE  output  2  0=IDLE, 1=GREEN, 2=YELLOW, 3=ALLRED
CUR  output  clog2(NCH)  currently or last granted channel
TMR  output  CNT_W  remaining cycles in the current phase, minus 1
PEND  output  NCH  latched pending requests

Behaviour:
- Reset (RN=0, asynchronous, takes effect immediately, including mid-phase):
  - PHASE=IDLE, CUR=0, TMR=0, PEND=0, GRN=0, YEL=0, RED=all ones.
- PEND update each edge: PEND <= (PEND | REQ) & ~clr.
  - clr is one-hot of the channel entering GREEN on that edge.
  - clr also covers CUR while PHASE=GREEN, so a request for the channel being served is dropped.
- Arbitration: candidates are V = PEND | REQ, sampled in the same cycle. Pick the first set bit of V searching CUR+1, CUR+2, ... wrapping modulo NCH, with CUR itself checked last.
- "Others pending" means V & ~onehot(CUR) != 0.
- IDLE:
  - If EN=1 and V!=0: go to GREEN on the next edge; CUR <= pick; TMR <= GREEN_T-1.
  - Otherwise stay in IDLE.
- GREEN: TMR decrements by 1 each cycle. At TMR==0:
  - If others are pending, or EN=0: go to YELLOW, TMR <= YELLOW_T-1.
  - Otherwise stay in GREEN with TMR held at 0 (rest-in-green). Leave on the first cycle the YELLOW condition becomes true.
- YELLOW: decrements; at TMR==0 go to ALLRED, TMR <= ALLRED_T-1.
- ALLRED: decrements; at TMR==0:
  - If EN=1 and V!=0: go to GREEN with the new pick (it may equal CUR if CUR is the only requester), TMR <= GREEN_T-1.
  - Otherwise go to IDLE, TMR <= 0.
- Outputs are registered with the state:
  - GRN = onehot(CUR) while PHASE=GREEN, else 0.
  - YEL = onehot(CUR) while PHASE=YELLOW, else 0.
  - GRN and YEL are never both non-zero. The registered one-hot outputs must be glitch-free.
- Latency: a REQ sampled in IDLE produces GRN on the next edge (1 cycle).
- Phase lengths are exactly GREEN_T, YELLOW_T and ALLRED_T cycles when no rest occurs.
- EN drop during YELLOW or ALLRED: the sequence completes, then goes to IDLE. EN does not truncate a running timer.
- A REQ and a CUR-wrap arriving in the same cycle are arbitrated together. No request is lost except the served channel's own request during GREEN.
- Every state is reachable and every state exits, so there is no lockup. Illegal PHASE encodings do not exist because the 2-bit state is fully used.

Test Plan:
Bench parameters for all scenarios: NCH=4, GREEN_T=4, YELLOW_T=2, ALLRED_T=1.
1. Reset, EN=1, REQ=0100 pulsed for 1 cycle -> next edge PHASE=1, CUR=2, GRN=0100, RED=1011, TMR=3. Then TMR 2,1,0 and held at 0 in rest-in-green; PEND=0000.
2. From rest in scenario 1, pulse REQ=0001 -> YEL=0100 for 2 cycles, then PHASE=3 with RED=1111 for 1 cycle, then GRN=0001, CUR=0.
3. Round robin: CUR=2 in GREEN, REQ=1011 held one cycle -> PEND=1011; grants follow order 3, 0, 1, each with a full 4/2/1 cycle sequence, and PEND ends at 0000.
4. EN=0 during GREEN at TMR=2 -> GREEN runs to TMR=0, then YELLOW 2 cycles, ALLRED 1 cycle, then IDLE with RED=1111, even with PEND=1000 (PEND retained).
5. RN asserted mid-YELLOW -> GRN=0, YEL=0, RED=1111, PHASE=0, PEND=0 immediately, without waiting for CK. After release with REQ=0, the block stays in IDLE.
6. Single requester: REQ=0010 held constantly -> GRN=0010 rests indefinitely. Never enters YELLOW; PEND bit 1 stays 0 while served.
